sk_decode_ctrl: RTL and testbench
=================================

Name: sk_decode_ctrl

Overview:
- Sequential front end for Kyber768 decapsulation key handling.
- Accepts the 2400-byte secret key as a byte stream over a valid/ready handshake and walks its four regions with an FSM.
- ByteDecode12-unpacks s[0..2] into a coefficient write stream for polynomial RAM, forwards the 1184 encapsulation-key bytes, and captures H(ek) and z into registers.
- Replaces wide combinational unpacking of the full secret-key vector in the decaps path.

Parameters:
KYBER_K, 3, number of polynomials in s
KYBER_N, 256, coefficients per polynomial
KYBER_R_WIDTH, 12, bits per packed coefficient
KYBER_Q, 3329, modulus used for range check

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a key load when idle
in_valid  in  1  byte valid
in_data  in  8  secret-key byte, byte 0 first
in_ready  out  1  byte accepted when in_valid && in_ready
coef_valid  out  1  coefficient write strobe
coef_poly  out  2  polynomial index 0..KYBER_K-1
coef_idx  out  8  coefficient index 0..255
coef_data  out  12  decoded coefficient
ek_valid  out  1  encapsulation-key byte strobe
ek_data  out  8  encapsulation-key byte
h_out  out  256  H(ek), byte 0 in bits [7:0]
z_out  out  256  implicit-rejection value z, byte 0 in bits [7:0]
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of load
malformed  out  1  sticky: some s coefficient >= KYBER_Q

Behaviour:
- Reset: every output and register is 0, and the FSM is in IDLE. Reset mid-load aborts immediately and discards partial state.
- Byte map:
  - s: bytes 0..1151.
  - ek: bytes 1152..2335.
  - h: bytes 2336..2367.
  - z: bytes 2368..2399.
- The 12-bit byte counter is held in byte_cnt.
- FSM states:
  - IDLE: in_ready=0. start moves to S_LOAD, clears byte_cnt and malformed, and sets busy the next cycle.
  - S_LOAD: in_ready=1. After byte 1151 is accepted, go to EK_LOAD.
  - EK_LOAD: in_ready=1. After byte 2335, go to H_LOAD.
  - H_LOAD: in_ready=1. After byte 2367, go to Z_LOAD.
  - Z_LOAD: in_ready=1. After byte 2399, go to DONE.
  - DONE: pulse done=1 for one cycle, busy=0, return to IDLE.
- start is ignored outside IDLE.
- byte_cnt increments only on handshake. in_valid low stalls with no state change.
- s unpacking:
  - Bytes are grouped in triples b0,b1,b2.
  - c0 = {b1[3:0], b0}; c1 = {b2, b1[7:4]}.
  - The cycle after b2 is accepted: coef_valid=1 with c0. The following cycle: coef_valid=1 with c1. coef_valid is a 2-cycle burst per triple.
  - coef_poly = (byte_cnt/384); coef_idx = 2*(triple index within poly) + {0,1}.
  - The next triple cannot complete within 2 cycles, so bursts never overlap.
  - The final c1 (poly 2, idx 255) may be emitted while in EK_LOAD.
- Range check: any emitted coefficient >= 3329 sets malformed. It stays set until the next accepted start, and coef_data is emitted unmodified.
- ek forwarding: each byte accepted in EK_LOAD appears on ek_data with ek_valid=1 the next cycle. There is no backpressure on ek or coef outputs.
- h/z capture: byte j of the region is written to bits [8j+7:8j]. Values hold after done until the next start clears them.
- Latency: done asserts the cycle after the handshake of byte 2399. Minimum load time is 2400 cycles + 1.

Test Plan:
- Reset then start; stream bytes 0x01,0x23,0x45 followed by zeros.
  -> First burst: (poly0, idx0, 0x301) then (poly0, idx1, 0x452).
  -> malformed=0; done after exactly 2401 cycles at full rate.
- s region with bytes 0xFF repeated.
  -> Every coef_data=0xFFF.
  -> malformed rises on the first coefficient and stays 1 after done.
- Known KAT secret key with random in_valid gaps.
  -> 768 coef writes match reference s.
  -> 1184 ek bytes match in order.
  -> h_out/z_out equal the KAT H(ek) and z.
  -> No output activity while stalled.
- Boundary: byte 1151 accepted.
  -> Last burst is (poly2, idx254/255); the idx255 write lands in the EK_LOAD cycle.
  -> The first ek_valid immediately follows byte 1152.
  -> coef_poly transitions 0→1 at byte 384 and 1→2 at byte 768.
- start pulsed at byte 500 mid-load.
  -> Ignored; load completes normally.
  -> A second start after done clears h_out, z_out and malformed.
- rst_n asserted at byte 1500.
  -> All outputs 0 immediately; in_ready=0.
  -> A fresh start and full key produces correct results.

Source files
------------

// File: rtl/sk_decode_ctrl.sv
// Kyber768 decapsulation-key loader: walks the 2400-byte secret key stream,
// ByteDecode12-unpacks s into coefficient writes, forwards ek and captures H(ek) and z.
`timescale 1ns/1ps
module sk_decode_ctrl #(
  parameter int KYBER_K       = 3,
  parameter int KYBER_N       = 256,
  parameter int KYBER_R_WIDTH = 12,
  parameter int KYBER_Q       = 3329
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         coef_valid,
  output logic [1:0]   coef_poly,
  output logic [7:0]   coef_idx,
  output logic [11:0]  coef_data,
  output logic         ek_valid,
  output logic [7:0]   ek_data,
  output logic [255:0] h_out,
  output logic [255:0] z_out,
  output logic         busy,
  output logic         done,
  output logic         malformed
);

  localparam int S_BYTES = KYBER_K * KYBER_N * KYBER_R_WIDTH / 8;
  localparam logic [11:0] S_LAST  = 12'(S_BYTES - 1);
  localparam logic [11:0] EK_LAST = 12'(2 * S_BYTES + 32 - 1);
  localparam logic [11:0] H_LAST  = 12'(2 * S_BYTES + 64 - 1);
  localparam logic [11:0] Z_LAST  = 12'(2 * S_BYTES + 96 - 1);

  typedef enum logic [2:0] {IDLE, S_LOAD, EK_LOAD, H_LOAD, Z_LOAD, DONE} state_t;

  state_t       state_reg, state_next;
  logic [11:0]  byte_cnt;
  logic [1:0]   phase_reg;
  logic [7:0]   b0_reg, b1_reg;
  logic [11:0]  c1_hold_reg;
  logic         c1_pend_reg;
  logic [9:0]   coef_cnt_reg;
  logic [9:0]   coef_addr_reg;
  logic [11:0]  coef_data_reg;
  logic         coef_valid_reg;
  logic         ek_valid_reg;
  logic [7:0]   ek_data_reg;
  logic [255:0] h_reg, z_reg;
  logic         malformed_reg;

  logic         hs, start_acc, emit_en;
  logic [11:0]  emit_data;

  assign in_ready  = (state_reg == S_LOAD) || (state_reg == EK_LOAD) ||
                     (state_reg == H_LOAD) || (state_reg == Z_LOAD);
  assign busy      = in_ready;
  assign done      = (state_reg == DONE);
  assign hs        = in_valid && in_ready;
  assign start_acc = start && (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = S_LOAD;
      S_LOAD:  if (hs && byte_cnt == S_LAST)  state_next = EK_LOAD;
      EK_LOAD: if (hs && byte_cnt == EK_LAST) state_next = H_LOAD;
      H_LOAD:  if (hs && byte_cnt == H_LAST)  state_next = Z_LOAD;
      Z_LOAD:  if (hs && byte_cnt == Z_LAST)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // c0 leaves the cycle after b2; c1 is held one extra cycle. A new triple
  // needs three handshakes, so the two sources never collide.
  always_comb begin
    emit_en   = 1'b0;
    emit_data = c1_hold_reg;
    if (hs && state_reg == S_LOAD && phase_reg == 2'd2) begin
      emit_en   = 1'b1;
      emit_data = {b1_reg[3:0], b0_reg};
    end else if (c1_pend_reg) begin
      emit_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt       <= '0;
      phase_reg      <= '0;
      b0_reg         <= '0;
      b1_reg         <= '0;
      c1_hold_reg    <= '0;
      c1_pend_reg    <= 1'b0;
      coef_cnt_reg   <= '0;
      coef_addr_reg  <= '0;
      coef_data_reg  <= '0;
      coef_valid_reg <= 1'b0;
      ek_valid_reg   <= 1'b0;
      ek_data_reg    <= '0;
      h_reg          <= '0;
      z_reg          <= '0;
      malformed_reg  <= 1'b0;
    end else begin
      coef_valid_reg <= 1'b0;
      ek_valid_reg   <= 1'b0;
      if (start_acc) begin
        byte_cnt      <= '0;
        phase_reg     <= '0;
        c1_pend_reg   <= 1'b0;
        coef_cnt_reg  <= '0;
        h_reg         <= '0;
        z_reg         <= '0;
        malformed_reg <= 1'b0;
      end
      if (hs) begin
        byte_cnt <= byte_cnt + 12'd1;
        case (state_reg)
          S_LOAD: begin
            case (phase_reg)
              2'd0:    begin b0_reg <= in_data; phase_reg <= 2'd1; end
              2'd1:    begin b1_reg <= in_data; phase_reg <= 2'd2; end
              default: begin
                c1_hold_reg <= {in_data, b1_reg[7:4]};
                phase_reg   <= 2'd0;
              end
            endcase
          end
          EK_LOAD: begin
            ek_valid_reg <= 1'b1;
            ek_data_reg  <= in_data;
          end
          // Region bases 2336 and 2368 are multiples of 32, so the low
          // five counter bits are the byte offset within h or z.
          H_LOAD:  h_reg[{byte_cnt[4:0], 3'b000} +: 8] <= in_data;
          Z_LOAD:  z_reg[{byte_cnt[4:0], 3'b000} +: 8] <= in_data;
          default: ;
        endcase
      end
      c1_pend_reg <= hs && state_reg == S_LOAD && phase_reg == 2'd2;
      if (emit_en) begin
        coef_valid_reg <= 1'b1;
        coef_data_reg  <= emit_data;
        coef_addr_reg  <= coef_cnt_reg;
        coef_cnt_reg   <= coef_cnt_reg + 10'd1;
        if (emit_data >= 12'(KYBER_Q)) malformed_reg <= 1'b1;
      end
    end
  end

  assign coef_valid = coef_valid_reg;
  assign coef_poly  = coef_addr_reg[9:8];
  assign coef_idx   = coef_addr_reg[7:0];
  assign coef_data  = coef_data_reg;
  assign ek_valid   = ek_valid_reg;
  assign ek_data    = ek_data_reg;
  assign h_out      = h_reg;
  assign z_out      = z_reg;
  assign malformed  = malformed_reg;

endmodule

// File: tb/tb_sk_decode_ctrl.sv
// Scoreboard bench for sk_decode_ctrl: stimulus pushes expected coef/ek writes,
// a negedge monitor pops and compares them as the DUT emits.
`timescale 1ns/1ps
module tb_sk_decode_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready, coef_valid, ek_valid, busy, done, malformed;
  logic [1:0]   coef_poly;
  logic [7:0]   coef_idx, ek_data;
  logic [11:0]  coef_data;
  logic [255:0] h_out, z_out;

  sk_decode_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .coef_valid(coef_valid), .coef_poly(coef_poly),
    .coef_idx(coef_idx), .coef_data(coef_data), .ek_valid(ek_valid), .ek_data(ek_data),
    .h_out(h_out), .z_out(z_out), .busy(busy), .done(done), .malformed(malformed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  poly;
    logic [7:0]  idx;
    logic [11:0] data;
  } coef_t;

  coef_t       coef_q[$];
  logic [7:0]  ek_q[$];
  logic [7:0]  key [2400];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          coef_seen = 0;
  int          ek_seen = 0;
  logic        malf_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference decode: coefficient k is bits [12k+11:12k] of the little-endian s stream.
  function automatic logic [11:0] model_coef(input int k);
    logic [11:0] c;
    int pos;
    for (int b = 0; b < 12; b++) begin
      pos  = 12 * k + b;
      c[b] = key[pos / 8][pos % 8];
    end
    return c;
  endfunction

  function automatic logic model_malformed();
    logic m = 1'b0;
    for (int k = 0; k < 768; k++) if (model_coef(k) >= 12'd3329) m = 1'b1;
    return m;
  endfunction

  task automatic push_for_byte(input int i, input bit hand_first);
    coef_t e;
    int k;
    if (i < 1152 && (i % 3) == 2) begin
      k = 2 * (i / 3);
      if (hand_first && i == 2) begin
        e = '{poly: 2'd0, idx: 8'd0, data: 12'h301}; coef_q.push_back(e);
        e = '{poly: 2'd0, idx: 8'd1, data: 12'h452}; coef_q.push_back(e);
      end else begin
        for (int j = 0; j < 2; j++) begin
          e.poly = 2'((k + j) / 256);
          e.idx  = 8'((k + j) % 256);
          e.data = model_coef(k + j);
          coef_q.push_back(e);
        end
      end
    end else if (i >= 1152 && i < 2336) begin
      ek_q.push_back(key[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {in_ready, busy, done, malformed, coef_valid, ek_valid}, '0);
    check({tag, "_coef"}, {coef_poly, coef_idx, coef_data, ek_data}, '0);
    check({tag, "_h"}, h_out, '0);
    check({tag, "_z"}, z_out, '0);
  endtask

  task automatic load_key(input int gap_pct, input int mid_start, input int reset_at,
                          input bit hand_first, input bit check_time);
    int t0, c0s, e0s, wait_n;
    logic [255:0] exp_h, exp_z;
    c0s = coef_seen;
    e0s = ek_seen;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
    check("start_busy", busy, 1'b1);
    check("start_clears", {h_out, z_out, malformed}, '0);
    for (int i = 0; i < 2400; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (i == reset_at) begin
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        coef_q.delete();
        ek_q.delete();
        return;
      end
      in_valid = 1'b1;
      in_data  = key[i];
      push_for_byte(i, hand_first);
      if (i == mid_start) start = 1'b1;
      wait_n = 0;
      while (!in_ready && wait_n < 20) begin
        @(posedge clk); #1;
        wait_n++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1 start = 1'b0;
    end
    in_valid = 1'b0;
    check("done_pulse", {done, busy}, 2'b10);
    if (check_time) check("load_cycles", 32'(cyc - t0 + 1), 32'd2401);
    for (int j = 0; j < 32; j++) begin
      exp_h[8*j +: 8] = key[2336 + j];
      exp_z[8*j +: 8] = key[2368 + j];
    end
    check("h_out", h_out, exp_h);
    check("z_out", z_out, exp_z);
    check("malformed_end", malformed, model_malformed());
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("coef_count", 32'(coef_seen - c0s), 32'd768);
    check("ek_count", 32'(ek_seen - e0s), 32'd1184);
    check("queues_drained", 64'({coef_q.size(), ek_q.size()}), 64'd0);
  endtask

  // Monitor: every DUT write must match the head of its queue.
  initial begin
    coef_t e;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (start && !busy && !done) malf_exp = 1'b0;
        if (coef_valid) begin
          if (coef_q.size() == 0) begin
            check("coef_unexpected", {coef_poly, coef_idx, coef_data}, '0);
          end else begin
            e = coef_q.pop_front();
            coef_seen++;
            check("coef", {coef_poly, coef_idx, coef_data}, e);
            malf_exp = malf_exp | (e.data >= 12'd3329);
            check("malformed", malformed, malf_exp);
          end
        end
        if (ek_valid) begin
          if (ek_q.size() == 0) begin
            check("ek_unexpected", ek_data, '0);
          end else begin
            b = ek_q.pop_front();
            ek_seen++;
            check("ek", ek_data, b);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 01 23 45 then zero s; full rate, exact latency
    for (int i = 0; i < 2400; i++) key[i] = (i < 1152) ? 8'h00 : 8'(i * 7 + 3);
    key[0] = 8'h01; key[1] = 8'h23; key[2] = 8'h45;
    load_key(0, -1, -1, 1'b1, 1'b1);

    // s all 0xFF: every coefficient 0xFFF, malformed sticky past done
    for (int i = 0; i < 2400; i++) key[i] = (i < 1152) ? 8'hFF : 8'(i * 13 + 1);
    load_key(0, -1, -1, 1'b0, 1'b1);
    check("malformed_sticky", malformed, 1'b1);

    // random key, random gaps, start pulsed at byte 500
    for (int i = 0; i < 2400; i++) key[i] = 8'($urandom);
    load_key(30, 500, -1, 1'b0, 1'b0);

    // reset mid-load at byte 1500, then a fresh full load
    for (int i = 0; i < 2400; i++) key[i] = 8'($urandom);
    load_key(0, -1, 1500, 1'b0, 1'b0);
    for (int i = 0; i < 2400; i++) key[i] = 8'($urandom);
    load_key(10, -1, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
